// File: rtl/rv32e_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : rv32e_mem_bridge
// Purpose  : Turns single-cycle load/store requests from an RV32E core memory
//            stage into a valid/ready request plus a response handshake on a
//            simple bus. The core is stalled while an access is in flight.
//            Misaligned accesses, bus error responses and bus timeouts are
//            reported through a sticky error record (flag, code, address).
// Ports    : clk, rst_n                    - clock, async active-low reset
//            core_addr/wdata/we/re         - core access request
//            core_rdata, core_stall        - load data and pipeline hold
//            bus_req_valid/ready           - request handshake
//            bus_addr/wdata/we             - request payload (held in REQ)
//            bus_rsp_valid/data/err        - bus response
//            err_flag/addr/code, err_clr   - sticky error record and clear
//            err_code: 01 misaligned, 10 bus error, 11 timeout
// Revision : 1.0 - initial release
// ============================================================================
module rv32e_mem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic        core_we,
    input  logic        core_re,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data,
    input  logic        bus_rsp_err,
    output logic        err_flag,
    output logic [31:0] err_addr,
    output logic [1:0]  err_code,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [16:0] c_TIMEOUT_LIM = 17'(TIMEOUT);
    localparam logic [1:0]  c_ERR_ALIGN   = 2'b01;
    localparam logic [1:0]  c_ERR_BUS     = 2'b10;
    localparam logic [1:0]  c_ERR_TMO     = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [31:0] r_rdata;
    logic [15:0] r_cnt;
    logic        r_err_flag;
    logic [1:0]  r_err_code;
    logic [31:0] r_err_addr;

    logic        w_core_req;
    logic        w_timeout;
    logic        w_latch;
    logic        w_rdata_ld;
    logic [31:0] w_rdata_val;
    logic        w_err_set;
    logic [1:0]  w_err_code;
    logic [31:0] w_err_addr;

    assign w_core_req = core_re | core_we;

    // Fires on the cycle whose closing edge would bring the counter to
    // TIMEOUT. Compared in 17 bits so a ready accepted on the limit cycle
    // still times out on the next WAIT_RSP cycle instead of wrapping.
    assign w_timeout = (({1'b0, r_cnt} + 17'd1) >= c_TIMEOUT_LIM);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_rdata_ld  = 1'b0;
        w_rdata_val = '0;
        w_err_set   = 1'b0;
        w_err_code  = '0;
        w_err_addr  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_core_req) begin
                    if (core_addr[1:0] == 2'b00) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_REQ;
                    end else begin
                        // No bus traffic; a load (write wins when both) gets 0.
                        w_state_nxt = ST_DONE;
                        w_err_set   = 1'b1;
                        w_err_code  = c_ERR_ALIGN;
                        w_err_addr  = core_addr;
                        w_rdata_ld  = ~core_we;
                    end
                end
            end
            ST_REQ: begin
                // Ready has priority over a timeout in the same cycle.
                if (bus_req_ready) begin
                    w_state_nxt = ST_WAIT_RSP;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                    w_err_set   = 1'b1;
                    w_err_code  = c_ERR_TMO;
                    w_err_addr  = r_addr;
                    w_rdata_ld  = ~r_we;
                end
            end
            ST_WAIT_RSP: begin
                if (bus_rsp_valid) begin
                    w_state_nxt = ST_DONE;
                    w_rdata_ld  = ~r_we;
                    w_rdata_val = bus_rsp_data;
                    if (bus_rsp_err) begin
                        w_err_set  = 1'b1;
                        w_err_code = c_ERR_BUS;
                        w_err_addr = r_addr;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                    w_err_set   = 1'b1;
                    w_err_code  = c_ERR_TMO;
                    w_err_addr  = r_addr;
                    w_rdata_ld  = ~r_we;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
            r_err_code <= '0;
            r_err_addr <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_latch) begin
                r_addr  <= core_addr;
                r_wdata <= core_wdata;
                r_we    <= core_we;
                r_cnt   <= '0;
            end else if ((r_state == ST_REQ) || (r_state == ST_WAIT_RSP)) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_rdata_ld) begin
                r_rdata <= w_rdata_val;
            end

            // Only the first error is recorded while the flag is up; an error
            // coinciding with err_clr counts as the first of a fresh record.
            if (w_err_set) begin
                r_err_flag <= 1'b1;
                if (!r_err_flag || err_clr) begin
                    r_err_code <= w_err_code;
                    r_err_addr <= w_err_addr;
                end
            end else if (err_clr) begin
                r_err_flag <= 1'b0;
                r_err_code <= '0;
                r_err_addr <= '0;
            end
        end
    end

    assign core_stall    = ((r_state == ST_IDLE) && w_core_req) ||
                           (r_state == ST_REQ) || (r_state == ST_WAIT_RSP);
    assign bus_req_valid = (r_state == ST_REQ);
    assign bus_addr      = r_addr;
    assign bus_wdata     = r_wdata;
    assign bus_we        = r_we;
    assign core_rdata    = r_rdata;
    assign err_flag      = r_err_flag;
    assign err_code      = r_err_code;
    assign err_addr      = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_rv32e_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32e_mem_bridge
// Purpose  : Directed bench for rv32e_mem_bridge. An access-level model turns
//            each access (address, data, ready delay, response delay, error)
//            into expected cycle counts and end results; a negedge compare
//            process checks every output each cycle against it. Literal
//            checks after key accesses pin the model itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32e_mem_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_we = 1'b0;
    logic        core_re = 1'b0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_data = '0;
    logic        bus_rsp_err = 1'b0;
    logic        err_flag;
    logic [31:0] err_addr;
    logic [1:0]  err_code;
    logic        err_clr = 1'b0;

    rv32e_mem_bridge #(.TIMEOUT(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_we       (core_we),
        .core_re       (core_re),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_we        (bus_we),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_data  (bus_rsp_data),
        .bus_rsp_err   (bus_rsp_err),
        .err_flag      (err_flag),
        .err_addr      (err_addr),
        .err_code      (err_code),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int valid_cnt = 0;

    // Model state: values visible on the outputs once the last access ended.
    logic [31:0] m_rdata = '0, m_baddr = '0, m_bwdata = '0, m_eaddr = '0;
    logic        m_bwe = 1'b0, m_eflag = 1'b0;
    logic [1:0]  m_ecode = '0;

    // Expected outputs for the current cycle.
    bit          chk_en = 1'b1;
    logic        e_stall = 1'b0, e_valid = 1'b0, e_bwe = 1'b0, e_eflag = 1'b0;
    logic [31:0] e_rdata = '0, e_baddr = '0, e_bwdata = '0, e_eaddr = '0;
    logic [1:0]  e_ecode = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, required %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (core_stall === 1'b1)    stall_cnt++;
            if (bus_req_valid === 1'b1) valid_cnt++;
            check("core_stall",    32'(core_stall),    32'(e_stall));
            check("bus_req_valid", 32'(bus_req_valid), 32'(e_valid));
            check("bus_addr",      bus_addr,           e_baddr);
            check("bus_wdata",     bus_wdata,          e_bwdata);
            check("bus_we",        32'(bus_we),        32'(e_bwe));
            check("core_rdata",    core_rdata,         e_rdata);
            check("err_flag",      32'(err_flag),      32'(e_eflag));
            check("err_code",      32'(err_code),      32'(e_ecode));
            check("err_addr",      err_addr,           e_eaddr);
        end
    end

    task automatic set_exp_from_model();
        e_stall = 1'b0; e_valid = 1'b0;
        e_baddr = m_baddr; e_bwdata = m_bwdata; e_bwe = m_bwe;
        e_rdata = m_rdata; e_eflag = m_eflag; e_ecode = m_ecode; e_eaddr = m_eaddr;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            set_exp_from_model();
        end
    endtask

    // One core access. rd: valid cycles before ready is raised; sd: WAIT
    // cycles before the response. clr_end: err_clr on the cycle whose edge
    // ends the access.
    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input bit re, input bit we, input int rd, input int sd,
                          input bit rerr, input logic [31:0] rdat, input bit clr_end);
        int reqlen, waitlen, done_k, m_to, vcnt, wcnt;
        bit hs, got_rsp, in_wait, hs_prev;
        logic [1:0]  new_code;
        logic [31:0] n_rdata, n_baddr, n_bwdata, n_eaddr;
        logic        n_bwe, n_eflag;
        logic [1:0]  n_ecode;
        n_rdata = m_rdata; n_baddr = m_baddr; n_bwdata = m_bwdata; n_bwe = m_bwe;
        n_eflag = m_eflag; n_ecode = m_ecode; n_eaddr = m_eaddr;
        reqlen = 0; waitlen = 0; new_code = 2'b00;
        if (a[1:0] != 2'b00) begin
            new_code = 2'b01;
            if (!we) n_rdata = '0;
        end else begin
            n_baddr = a; n_bwdata = wd; n_bwe = we;
            hs = (rd <= T - 1);
            reqlen = hs ? rd + 1 : T;
            got_rsp = 1'b0;
            if (hs) begin
                m_to = (T - 2 - rd > 0) ? T - 2 - rd : 0;
                got_rsp = (sd <= m_to);
                waitlen = got_rsp ? sd + 1 : m_to + 1;
            end
            if (got_rsp) begin
                if (!we) n_rdata = rdat;
                if (rerr) new_code = 2'b10;
            end else begin
                if (!we) n_rdata = '0;
                new_code = 2'b11;
            end
        end
        done_k = 1 + reqlen + waitlen;
        if (new_code != 2'b00) begin
            if (!m_eflag || clr_end) begin
                n_ecode = new_code;
                n_eaddr = a;
            end
            n_eflag = 1'b1;
        end else if (clr_end) begin
            n_eflag = 1'b0; n_ecode = '0; n_eaddr = '0;
        end

        vcnt = 0; wcnt = 0; in_wait = 1'b0; hs_prev = 1'b0;
        for (int k = 0; k <= done_k + 1; k++) begin
            @(posedge clk); #1;
            core_re    = (k <= done_k) ? re : 1'b0;
            core_we    = (k <= done_k) ? we : 1'b0;
            core_addr  = a;
            core_wdata = wd;
            err_clr    = clr_end && (k == done_k - 1);
            // Bus agent: reacts only to what it sees on the bus.
            if (hs_prev) begin in_wait = 1'b1; wcnt = 0; end
            bus_rsp_valid = in_wait && (wcnt == sd);
            bus_rsp_err   = bus_rsp_valid && rerr;
            bus_rsp_data  = bus_rsp_valid ? rdat : 32'h0;
            if (bus_rsp_valid) in_wait = 1'b0;
            else if (in_wait)  wcnt++;
            bus_req_ready = bus_req_valid && (vcnt >= rd);
            if (bus_req_valid) vcnt++;
            hs_prev = bus_req_valid && bus_req_ready;

            e_stall  = (k < done_k);
            e_valid  = (k >= 1) && (k <= reqlen);
            e_baddr  = (k >= 1) ? n_baddr  : m_baddr;
            e_bwdata = (k >= 1) ? n_bwdata : m_bwdata;
            e_bwe    = (k >= 1) ? n_bwe    : m_bwe;
            e_rdata  = (k >= done_k) ? n_rdata : m_rdata;
            e_eflag  = (k >= done_k) ? n_eflag : m_eflag;
            e_ecode  = (k >= done_k) ? n_ecode : m_ecode;
            e_eaddr  = (k >= done_k) ? n_eaddr : m_eaddr;
        end
        m_rdata = n_rdata; m_baddr = n_baddr; m_bwdata = n_bwdata; m_bwe = n_bwe;
        m_eflag = n_eflag; m_ecode = n_ecode; m_eaddr = n_eaddr;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; err_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        err_clr = 1'b1;
        set_exp_from_model();
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_eflag = 1'b0; m_ecode = '0; m_eaddr = '0;
        set_exp_from_model();
    endtask

    initial begin
        set_exp_from_model();
        idle_cycles(3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // Immediate-handshake read.
        stall_cnt = 0; valid_cnt = 0;
        access(32'h0000_0100, 32'h0, 1, 0, 0, 0, 0, 32'hCAFE_F00D, 0);
        check("read_rdata_lit", core_rdata, 32'hCAFE_F00D);
        check("read_addr_lit",  bus_addr,   32'h0000_0100);
        check("read_we_lit",    32'(bus_we), 32'd0);
        check("read_stall_cycles", 32'(stall_cnt), 32'd3);

        // Write with re+we, ready on the fifth valid cycle.
        valid_cnt = 0;
        access(32'h0000_0200, 32'h1234_5678, 1, 1, 4, 0, 0, 32'hFFFF_FFFF, 0);
        check("write_valid_cycles", 32'(valid_cnt), 32'd5);
        check("write_rdata_lit",    core_rdata, 32'hCAFE_F00D);
        check("write_we_lit",       32'(bus_we), 32'd1);
        check("write_noerr_lit",    32'(err_flag), 32'd0);

        // Misaligned read.
        valid_cnt = 0;
        access(32'h0000_0102, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0);
        check("mis_valid_cycles", 32'(valid_cnt), 32'd0);
        check("mis_rdata_lit",    core_rdata, 32'h0);
        check("mis_code_lit",     32'(err_code), 32'd1);
        check("mis_addr_lit",     err_addr, 32'h0000_0102);
        pulse_clr();

        // Timeout in REQ, then a second error before clearing.
        valid_cnt = 0;
        access(32'h0000_0400, 32'h0, 1, 0, 1000, 0, 0, 32'h0, 0);
        check("tmo_valid_cycles", 32'(valid_cnt), 32'd8);
        check("tmo_code_lit",     32'(err_code), 32'd3);
        access(32'h0000_0503, 32'h5, 0, 1, 0, 0, 0, 32'h0, 0);
        check("tmo2_addr_lit",    err_addr, 32'h0000_0400);
        check("tmo2_code_lit",    32'(err_code), 32'd3);
        pulse_clr();

        // Bus error response on a read, then clear.
        access(32'h0000_0300, 32'h0, 1, 0, 1, 2, 1, 32'hAAAA_5555, 0);
        check("berr_rdata_lit", core_rdata, 32'hAAAA_5555);
        check("berr_code_lit",  32'(err_code), 32'd2);
        check("berr_addr_lit",  err_addr, 32'h0000_0300);
        pulse_clr();
        check("clr_flag_lit", 32'(err_flag), 32'd0);
        check("clr_code_lit", 32'(err_code), 32'd0);
        check("clr_addr_lit", err_addr, 32'h0);

        // Ready on the limit cycle, response on the limit cycle, and a
        // timeout in WAIT_RSP with the late response landing in DONE.
        access(32'h0000_0010, 32'h0, 1, 0, 7, 0, 0, 32'h1111_1111, 0);
        check("rdy_at_limit_lit", core_rdata, 32'h1111_1111);
        access(32'h0000_0020, 32'h0, 1, 0, 2, 4, 0, 32'h2222_2222, 0);
        check("rsp_at_limit_lit", core_rdata, 32'h2222_2222);
        check("limit_noerr_lit",  32'(err_flag), 32'd0);
        access(32'h0000_0030, 32'h9, 0, 1, 2, 5, 0, 32'h3333_3333, 0);
        check("wait_tmo_code_lit", 32'(err_code), 32'd3);
        check("wait_tmo_rdata_lit", core_rdata, 32'h2222_2222);

        // New error coinciding with err_clr replaces the record.
        access(32'h0000_0007, 32'h0, 1, 0, 0, 0, 0, 32'h0, 1);
        check("clr_vs_err_addr_lit", err_addr, 32'h0000_0007);
        check("clr_vs_err_code_lit", 32'(err_code), 32'd1);
        pulse_clr();

        // Reset in WAIT_RSP, late response after release.
        chk_en = 1'b0;
        @(posedge clk); #1;
        core_re = 1'b1; core_addr = 32'h0000_0600;
        @(posedge clk); #1;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        check("rst_pre_wait_valid", 32'(bus_req_valid), 32'd0);
        check("rst_pre_wait_stall", 32'(core_stall), 32'd1);
        core_re = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_stall", 32'(core_stall), 32'd0);
        check("rst_async_addr",  bus_addr, 32'h0);
        m_rdata = '0; m_baddr = '0; m_bwdata = '0; m_bwe = 1'b0;
        m_eflag = 1'b0; m_ecode = '0; m_eaddr = '0;
        set_exp_from_model();
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0; bus_rsp_data = 32'h0;
        idle_cycles(2);
        check("rst_rdata_lit", core_rdata, 32'h0);
        check("rst_flag_lit",  32'(err_flag), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
